// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
//
// Purpose:
//   Owns the architectural HI/LO register pair of a 32-bit MIPS-style core
//   and sequences an external multi-cycle divider. MTHI/MTLO are written
//   straight into HI/LO. A DIV/DIVU with a non-zero divisor is handed to the
//   divider core, and the core's {HI,LO} answer is copied into HI/LO only
//   in the CAPTURE state. A divide by zero never reaches the core. It leaves
//   HI/LO untouched, raises the sticky div0 flag and pulses done one cycle
//   later. A pipeline flush abandons an in-flight division. The controller
//   then drains the core, because the core cannot be stopped, and throws
//   its answer away.
//
// Ports:
//   Clk          sole clock, rising edge
//   Reset        synchronous, active-high reset
//   req_valid    pipeline presents a HI/LO operation
//   req_op       0=DIV (signed), 1=DIVU, 2=MTHI, 3=MTLO
//   req_a        dividend, or write data for MTHI/MTLO
//   req_b        divisor (ignored for MTHI/MTLO)
//   req_ready    operation accepted on an edge where req_valid&req_ready
//   flush        pipeline exception, cancels an in-flight division
//   hi, lo       architectural HI and LO
//   hilo_busy    HI/LO not final; MFHI/MFLO must stall while high
//   done         one-cycle pulse when an accepted DIV/DIVU retires
//   div0         sticky: last retired division had a zero divisor
//   core_start   start pulse to the divider core
//   core_sign    signed-mode select to the divider core
//   core_a       dividend to the core
//   core_b       divisor to the core
//   core_we      core HI/LO write enables, permanently zero
//   core_busy    core is iterating
//   core_result  core output {HI,LO}, valid one cycle after core_busy falls
// ---------------------------------------------------------------------------
module div_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hilo_busy,
    output logic        done,
    output logic        div0,
    output logic        core_start,
    output logic        core_sign,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic [1:0]  core_we,
    input  logic        core_busy,
    input  logic [63:0] core_result
);

    // Controller states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;

    // Operation codes carried on req_op
    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    logic [2:0]  r_state;
    logic [2:0]  w_stateNext;
    logic        r_drainArmed;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_div0;
    logic        r_zeroDone;
    logic        r_coreSign;
    logic [31:0] r_coreA;
    logic [31:0] r_coreB;

    logic        w_accept;
    logic        w_isDiv;
    logic        w_divZero;
    logic        w_divIssue;
    logic        w_writeHi;
    logic        w_writeLo;
    logic        w_capture;

    // Requests are only taken while the controller is idle and the core is
    // quiet. The core may still be busy in IDLE after a reset hit a running
    // division. A flush in the same cycle also blocks acceptance, because
    // the requesting instruction is being cancelled.
    assign req_ready = (r_state == S_IDLE) & ~core_busy & ~flush;
    assign w_accept  = req_valid & req_ready;

    // Decode of the accepted request.
    assign w_isDiv    = (req_op == OP_DIV) | (req_op == OP_DIVU);
    assign w_divZero  = w_accept & w_isDiv & (req_b == 32'd0);
    assign w_divIssue = w_accept & w_isDiv & (req_b != 32'd0);
    assign w_writeHi  = w_accept & (req_op == OP_MTHI);
    assign w_writeLo  = w_accept & (req_op == OP_MTLO);

    // A flush landing in CAPTURE kills the write-back and the done pulse.
    assign w_capture = (r_state == S_CAPTURE) & ~flush;

    // Next-state logic. Flush has no effect in IDLE. From any in-flight
    // state it diverts to DRAIN. The start pulse is combinational on ISSUE,
    // so it still goes out in a flushed ISSUE cycle, and DRAIN must wait for
    // that division too.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_divIssue) begin
                    w_stateNext = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_stateNext = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                w_stateNext = flush ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (flush) begin
                    w_stateNext = S_DRAIN;
                end else if (!core_busy) begin
                    w_stateNext = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_stateNext = flush ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                // The first DRAIN cycle can still see a stale low core_busy
                // from before the core reacted to the start pulse, so it is
                // ignored.
                if (r_drainArmed && !core_busy) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State register. Reset wins over a simultaneous flush because it is
    // checked first. r_drainArmed is set only from the second DRAIN cycle on.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_drainArmed <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_drainArmed <= (r_state == S_DRAIN);
        end
    end

    // HI/LO are private registers. Only an accepted MTHI/MTLO or an
    // unflushed CAPTURE may change them. In particular core_result is never
    // looked at outside CAPTURE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_capture) begin
            r_hi <= core_result[63:32];
            r_lo <= core_result[31:0];
        end else begin
            if (w_writeHi) begin
                r_hi <= req_a;
            end
            if (w_writeLo) begin
                r_lo <= req_a;
            end
        end
    end

    // Divide-by-zero bookkeeping. The sticky flag tracks the most recently
    // accepted division. The retire pulse for the zero case comes one cycle
    // after acceptance, and the core is never involved.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_div0     <= 1'b0;
            r_zeroDone <= 1'b0;
        end else begin
            r_zeroDone <= w_divZero;
            if (w_divZero) begin
                r_div0 <= 1'b1;
            end else if (w_divIssue) begin
                r_div0 <= 1'b0;
            end
        end
    end

    // Operand latch for the core. Loading happens only at the accept edge,
    // so the operands stay stable from ISSUE through CAPTURE no matter what
    // the pipeline drives on req_a/req_b afterwards.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_coreSign <= 1'b0;
            r_coreA    <= 32'd0;
            r_coreB    <= 32'd0;
        end else if (w_divIssue) begin
            r_coreSign <= (req_op == OP_DIV);
            r_coreA    <= req_a;
            r_coreB    <= req_b;
        end
    end

    // Output drive.
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign hilo_busy  = (r_state != S_IDLE);
    assign done       = r_zeroDone | w_capture;
    assign div0       = r_div0;
    assign core_start = (r_state == S_ISSUE);
    assign core_sign  = r_coreSign;
    assign core_a     = r_coreA;
    assign core_b     = r_coreB;
    assign core_we    = 2'b00;

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl
//
// Self-checking bench for div_ctrl. A behavioural divider core with a
// random, per-operation latency sits next to the DUT. A plain-arithmetic
// reference model holds the expected HI, LO and div0 values.
// ---------------------------------------------------------------------------
module tb_div_ctrl;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    logic        Clk;
    logic        Reset;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo_busy;
    logic        done;
    logic        div0;
    logic        core_start;
    logic        core_sign;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [1:0]  core_we;
    logic        core_busy;
    logic [63:0] core_result = 64'd0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDiv0;

    // Behavioural core state
    int          nextLat    = 1;
    int          coreLeft   = 0;
    logic        resStage   = 1'b0;
    logic [63:0] pendRes    = 64'd0;
    int          startCount = 0;

    div_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .flush       (flush),
        .hi          (hi),
        .lo          (lo),
        .hilo_busy   (hilo_busy),
        .done        (done),
        .div0        (div0),
        .core_start  (core_start),
        .core_sign   (core_sign),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_we     (core_we),
        .core_busy   (core_busy),
        .core_result (core_result)
    );

    // Free-running clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // MIPS division semantics in 64-bit arithmetic, so that
    // 0x80000000 / -1 is well defined. The result is {remainder, quotient}.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Divider core model. core_start is sampled at the rising edge.
    // core_busy is then high for nextLat cycles. In the first cycle after
    // busy falls the result bus carries junk, and the real answer appears
    // (and stays) one cycle later.
    assign core_busy = (coreLeft > 0);

    always @(posedge Clk) begin
        if (core_start) begin
            coreLeft <= nextLat;
            pendRes  <= refDiv(core_sign, core_a, core_b);
        end else if (coreLeft > 0) begin
            coreLeft <= coreLeft - 1;
            if (coreLeft == 1) begin
                resStage    <= 1'b1;
                core_result <= 64'hDEADBEEF_0BADF00D;
            end
        end
        if (resStage) begin
            resStage    <= 1'b0;
            core_result <= pendRes;
        end
    end

    // Count every cycle in which the core is told to start
    always @(posedge Clk) begin
        if (core_start) begin
            startCount <= startCount + 1;
        end
    end

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one complete operation. The task waits for the DUT to be ready,
    // presents the request, follows it to retirement and checks the
    // architectural outcome against the reference model. It starts and
    // ends at a falling edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int lat);
        int          guard;
        int          cyc;
        int          starts0;
        logic        stable;
        logic [63:0] res;
        nextLat = lat;
        guard = 0;
        while (!req_ready && guard < 300) begin
            @(negedge Clk);
            guard++;
        end
        checkOutput("readyWait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        starts0   = startCount;
        @(negedge Clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        if (op == OP_MTHI || op == OP_MTLO) begin
            if (op == OP_MTHI) expHi = a;
            else expLo = a;
            checkOutput("mtHi", 64'(hi), 64'(expHi));
            checkOutput("mtLo", 64'(lo), 64'(expLo));
            checkOutput("mtDone", 64'(done), 64'd0);
            checkOutput("mtBusy", 64'(hilo_busy), 64'd0);
            checkOutput("mtStarts", 64'(startCount - starts0), 64'd0);
        end else if (b == 32'd0) begin
            expDiv0 = 1'b1;
            checkOutput("zDone", 64'(done), 64'd1);
            checkOutput("zBusy", 64'(hilo_busy), 64'd0);
            checkOutput("zHi", 64'(hi), 64'(expHi));
            checkOutput("zLo", 64'(lo), 64'(expLo));
            checkOutput("zDiv0", 64'(div0), 64'(expDiv0));
            @(negedge Clk);
            checkOutput("zDoneOnce", 64'(done), 64'd0);
            checkOutput("zStarts", 64'(startCount - starts0), 64'd0);
        end else begin
            res    = refDiv(op == OP_DIV, a, b);
            cyc    = 1;
            stable = 1'b1;
            while (!done && cyc < 300) begin
                if (core_a !== a || core_b !== b || core_sign !== (op == OP_DIV) ||
                    hilo_busy !== 1'b1 || core_we !== 2'b00)
                    stable = 1'b0;
                @(negedge Clk);
                cyc++;
            end
            checkOutput("latency", 64'(cyc), 64'(3 + lat));
            checkOutput("heldOperands", 64'(stable), 64'd1);
            checkOutput("hiBeforeCapture", 64'(hi), 64'(expHi));
            @(negedge Clk);
            expHi   = res[63:32];
            expLo   = res[31:0];
            expDiv0 = 1'b0;
            checkOutput("divHi", 64'(hi), 64'(expHi));
            checkOutput("divLo", 64'(lo), 64'(expLo));
            checkOutput("divDiv0", 64'(div0), 64'(expDiv0));
            checkOutput("divDoneOnce", 64'(done), 64'd0);
            checkOutput("divBusyAfter", 64'(hilo_busy), 64'd0);
            checkOutput("divStarts", 64'(startCount - starts0), 64'd1);
        end
    endtask

    // Directed scenarios followed by a random mix, all in one linear sequence.
    initial begin
        int          cyc;
        int          doneCyc;
        logic        sawDone;
        logic        earlyIdle;
        logic [63:0] res;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        Reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        expHi     = 32'd0;
        expLo     = 32'd0;
        expDiv0   = 1'b0;

        // Reset state
        repeat (2) @(negedge Clk);
        checkOutput("rstHi", 64'(hi), 64'd0);
        checkOutput("rstLo", 64'(lo), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);
        checkOutput("rstDiv0", 64'(div0), 64'd0);
        checkOutput("rstStart", 64'(core_start), 64'd0);
        checkOutput("rstSign", 64'(core_sign), 64'd0);
        checkOutput("rstCoreA", 64'(core_a), 64'd0);
        checkOutput("rstCoreB", 64'(core_b), 64'd0);
        checkOutput("rstBusy", 64'(hilo_busy), 64'd0);
        checkOutput("rstWe", 64'(core_we), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("rstReady", 64'(req_ready), 64'd1);

        // DIVU 7/2, then signed -7/2
        applyStimulus(OP_DIVU, 32'd7, 32'd2, 3);
        checkOutput("divu72Hi", 64'(hi), 64'd1);
        checkOutput("divu72Lo", 64'(lo), 64'd3);
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 4);
        checkOutput("divNeg7Hi", 64'(hi), 64'hFFFFFFFF);
        checkOutput("divNeg7Lo", 64'(lo), 64'hFFFFFFFD);

        // MTHI, then divide by zero
        applyStimulus(OP_MTHI, 32'h1234, 32'd0, 1);
        applyStimulus(OP_DIVU, 32'd55, 32'd0, 1);
        checkOutput("zeroKeepsHi", 64'(hi), 64'h1234);

        // Flush in IDLE: the request must not be taken
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_MTHI;
        req_a     = 32'hABCD;
        #1;
        checkOutput("flushIdleReady", 64'(req_ready), 64'd0);
        @(negedge Clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        checkOutput("flushIdleHi", 64'(hi), 64'(expHi));
        checkOutput("flushIdleBusy", 64'(hilo_busy), 64'd0);

        // DIVU 100/7 flushed in the third RUN cycle
        applyStimulus(OP_DIVU, 32'd1000, 32'd13, 2);
        nextLat   = 6;
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd100;
        req_b     = 32'd7;
        @(negedge Clk);
        req_valid = 1'b0;
        repeat (4) @(negedge Clk);
        checkOutput("flushRunDone", 64'(done), 64'd0);
        flush = 1'b1;
        @(negedge Clk);
        flush     = 1'b0;
        cyc       = 6;
        sawDone   = 1'b0;
        earlyIdle = 1'b0;
        while (!req_ready && cyc < 300) begin
            if (done) sawDone = 1'b1;
            if (!hilo_busy) earlyIdle = 1'b1;
            @(negedge Clk);
            cyc++;
        end
        checkOutput("flushReadyCycle", 64'(cyc), 64'd9);
        checkOutput("flushBusyAtReady", 64'(core_busy), 64'd0);
        checkOutput("flushNoDone", 64'(sawDone), 64'd0);
        checkOutput("flushHiloBusyHeld", 64'(earlyIdle), 64'd0);
        repeat (4) @(negedge Clk);
        checkOutput("flushHiKept", 64'(hi), 64'(expHi));
        checkOutput("flushLoKept", 64'(lo), 64'(expLo));

        // MTLO offered while the divider is running
        nextLat   = 5;
        res       = refDiv(1'b0, 32'd1000, 32'd7);
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd1000;
        req_b     = 32'd7;
        @(negedge Clk);
        req_valid = 1'b0;
        repeat (2) @(negedge Clk);
        req_valid = 1'b1;
        req_op    = OP_MTLO;
        req_a     = 32'h5A5A0001;
        req_b     = 32'd0;
        checkOutput("mtloRunReady", 64'(req_ready), 64'd0);
        cyc     = 3;
        doneCyc = 0;
        while (!req_ready && cyc < 300) begin
            if (done) doneCyc = cyc;
            @(negedge Clk);
            cyc++;
        end
        checkOutput("mtloDoneCycle", 64'(doneCyc), 64'd8);
        checkOutput("mtloReadyCycle", 64'(cyc), 64'd9);
        @(negedge Clk);
        req_valid = 1'b0;
        expHi     = res[63:32];
        expLo     = 32'h5A5A0001;
        expDiv0   = 1'b0;
        checkOutput("mtloHi", 64'(hi), 64'(expHi));
        checkOutput("mtloLo", 64'(lo), 64'(expLo));

        // Reset in the middle of RUN
        nextLat   = 8;
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = $urandom;
        req_b     = 32'd3;
        @(negedge Clk);
        req_valid = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        flush = 1'b1;
        @(negedge Clk);
        Reset   = 1'b0;
        flush   = 1'b0;
        expHi   = 32'd0;
        expLo   = 32'd0;
        expDiv0 = 1'b0;
        checkOutput("midRstHi", 64'(hi), 64'd0);
        checkOutput("midRstLo", 64'(lo), 64'd0);
        checkOutput("midRstReady", 64'(req_ready), 64'd0);
        checkOutput("midRstBusy", 64'(hilo_busy), 64'd0);
        cyc     = 5;
        sawDone = 1'b0;
        while (!req_ready && cyc < 300) begin
            if (done) sawDone = 1'b1;
            @(negedge Clk);
            cyc++;
        end
        checkOutput("midRstReadyCycle", 64'(cyc), 64'd10);
        checkOutput("midRstNoDone", 64'(sawDone), 64'd0);
        repeat (3) @(negedge Clk);
        checkOutput("orphanHi", 64'(hi), 64'd0);
        applyStimulus(OP_DIVU, 32'd9, 32'd3, 2);
        checkOutput("after93Hi", 64'(hi), 64'd0);
        checkOutput("after93Lo", 64'(lo), 64'd3);

        // Signed overflow corner
        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1);

        // Random mix
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb, $urandom_range(1, 8));
        end

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
